// File: rtl/cas_pkg.sv
// Shared definitions for the cassette FSK playback path: FSM state encoding
// and default half-period lengths for the 42.954 MHz system clock.
package cas_pkg;

  typedef enum logic [1:0] {
    CAS_IDLE = 2'd0,
    CAS_HIGH = 2'd1,
    CAS_LOW  = 2'd2
  } cas_state_e;

  localparam int CAS_CLK_HZ = 42_954_000;

  // Half-periods rounded to the nearest clock: a 0 bit is one 1200 Hz cycle,
  // a 1 bit is one 2400 Hz cycle.
  localparam int DEF_HALF_BIT0 = (CAS_CLK_HZ + 1200) / 2400;  // 17898
  localparam int DEF_HALF_BIT1 = (CAS_CLK_HZ + 2400) / 4800;  // 8949
  localparam int DEF_CNT_W     = 15;

endpackage

// File: rtl/cas_fsk_tx.sv
// Cassette playback transmitter. Takes image bytes over valid/ready into a
// one-byte holding register and serialises them LSB first as one square-wave
// cycle per bit (long cycle for 0, short cycle for 1) on casdout. The motor
// input freezes the waveform mid-cycle; the input handshake keeps running.
module cas_fsk_tx
  import cas_pkg::*;
#(
  parameter int HALF_BIT0 = DEF_HALF_BIT0,
  parameter int HALF_BIT1 = DEF_HALF_BIT1,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       motor,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       casdout,
  output logic       busy,
  output logic       byte_done
);

  cas_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       sh_q, sh_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             casdout_q, casdout_d;
  logic [7:0]       hold_data;
  logic             hold_valid;
  logic             load;

  // Half-period reload value (minus one) for the bit about to be sent.
  function automatic logic [CNT_W-1:0] half_m1(input logic bit_val);
    return bit_val ? CNT_W'(HALF_BIT1 - 1) : CNT_W'(HALF_BIT0 - 1);
  endfunction

  // Holding register: fills on handshake, empties when the serialiser loads it.
  // Fill and load are exclusive because in_ready is low whenever hold is full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_data  <= '0;
      hold_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      // NOTE: state registers use non-blocking assignment so every flop samples
      // pre-edge values regardless of statement order.
      hold_data  <= in_data;
      hold_valid <= 1'b1;
    end else if (load) begin
      hold_valid <= 1'b0;
    end
  end

  // Next-state logic: everything except the handshake holds while motor is low.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    casdout_d = casdout_q;
    load      = 1'b0;
    byte_done = 1'b0;

    if (motor) begin
      case (state_q)
        CAS_IDLE: begin
          casdout_d = 1'b0;
          if (hold_valid) load = 1'b1;
        end
        CAS_HIGH: begin
          if (cnt_q == '0) begin
            cnt_d     = half_m1(sh_q[0]);
            casdout_d = 1'b0;
            state_d   = CAS_LOW;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        CAS_LOW: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (bit_cnt_q != 3'd7) begin
            sh_d      = {1'b0, sh_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            cnt_d     = half_m1(sh_q[1]);
            casdout_d = 1'b1;
            state_d   = CAS_HIGH;
          end else begin
            // Last half of bit 7: chain straight into the held byte if any.
            byte_done = 1'b1;
            if (hold_valid) load = 1'b1;
            else            state_d = CAS_IDLE;
          end
        end
        default: begin
          casdout_d = 1'b0;
          state_d   = CAS_IDLE;
        end
      endcase
    end

    if (load) begin
      sh_d      = hold_data;
      bit_cnt_d = 3'd0;
      cnt_d     = half_m1(hold_data[0]);
      casdout_d = 1'b1;
      state_d   = CAS_HIGH;
    end
  end

  // Serialiser state register; reset drops casdout immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= CAS_IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      bit_cnt_q <= '0;
      casdout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      casdout_q <= casdout_d;
    end
  end

  assign in_ready = ~hold_valid;
  assign casdout  = casdout_q;
  assign busy     = (state_q != CAS_IDLE);

endmodule

// File: tb/tb_cas_fsk_tx.sv
// Bench for cas_fsk_tx. The reference model is a queue of expected waveform
// samples: each byte handed to the transmitter expands into its full list of
// high/low clock samples, which is consumed one entry per clock while the
// motor runs.
module tb_cas_fsk_tx;

  localparam int HB0 = 8;
  localparam int HB1 = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       motor = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, casdout, busy, byte_done;

  cas_fsk_tx #(.HALF_BIT0(HB0), .HALF_BIT1(HB1), .CNT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .motor    (motor),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .casdout  (casdout),
    .busy     (busy),
    .byte_done(byte_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic level;
    logic last;
  } seg_t;

  seg_t       stream[$];   // expected samples of the byte(s) being played
  logic [7:0] src_q[$];    // bytes the upstream source still has to deliver
  logic       src_en = 1'b0;
  logic       hold_full = 1'b0;
  logic [7:0] hold_byte = 8'h00;

  int n_checks = 0;
  int n_errors = 0;
  int busy_cycles = 0;
  int done_pulses = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expand a byte into its waveform: per bit, h samples high then h low.
  function automatic void push_byte(input logic [7:0] b);
    seg_t s;
    for (int i = 0; i < 8; i++) begin
      int h = b[i] ? HB1 : HB0;
      for (int k = 0; k < 2 * h; k++) begin
        s.level = (k < h);
        s.last  = (i == 7) && (k == 2 * h - 1);
        stream.push_back(s);
      end
    end
  endfunction

  // One clock: called at a negedge with motor/src_en chosen by the caller.
  task automatic cycle();
    logic old_full, acc;
    seg_t s;
    in_valid = (src_q.size() != 0) && src_en;
    in_data  = (src_q.size() != 0) ? src_q[0] : 8'h00;
    #1;
    check("casdout", casdout, (stream.size() != 0) ? stream[0].level : 1'b0);
    check("busy", busy, stream.size() != 0);
    check("in_ready", in_ready, !hold_full);
    check("byte_done", byte_done, motor && (stream.size() != 0) && stream[0].last);
    if (busy) busy_cycles++;
    if (byte_done) done_pulses++;
    @(posedge clk);
    old_full = hold_full;
    acc      = in_valid && !old_full;
    if (motor) begin
      if (stream.size() != 0) begin
        s = stream.pop_front();
        if (s.last && old_full) begin
          push_byte(hold_byte);
          hold_full = 1'b0;
        end
      end else if (old_full) begin
        push_byte(hold_byte);
        hold_full = 1'b0;
      end
    end
    if (acc) begin
      hold_byte = in_data;
      hold_full = 1'b1;
      void'(src_q.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_counts();
    busy_cycles = 0;
    done_pulses = 0;
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check("rst_casdout", casdout, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_byte_done", byte_done, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // 0x01: one short bit then seven long bits, 120 cycles of activity.
    motor = 1'b1;
    src_en = 1'b1;
    clear_counts();
    src_q.push_back(8'h01);
    run(130);
    check("t01_busy_len", busy_cycles, 120);
    check("t01_done_cnt", done_pulses, 1);

    // Idle 20 cycles, then a new byte from an empty hold.
    run(20);
    src_q.push_back(8'h3c);
    run(110);

    // 0xFF then 0x00 back to back: 64 + 128 cycles, no gap.
    clear_counts();
    src_q.push_back(8'hff);
    src_q.push_back(8'h00);
    run(200);
    check("b2b_busy_len", busy_cycles, 192);
    check("b2b_done_cnt", done_pulses, 2);

    // 0x00 with a 50-cycle motor stop three cycles into the first HIGH.
    clear_counts();
    src_q.push_back(8'h00);
    run(5);
    motor = 1'b0;
    run(50);
    motor = 1'b1;
    run(140);
    check("pause_busy_len", busy_cycles, 178);
    check("pause_done_cnt", done_pulses, 1);

    // Asynchronous reset in bit 3 of 0xA5 with a second byte held.
    src_q.push_back(8'ha5);
    src_q.push_back(8'h5a);
    run(39);
    #3;
    reset = 1'b0;
    #1;
    check("mid_rst_casdout", casdout, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    stream.delete();
    src_q.delete();
    hold_full = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run(30);

    // Motor off: first byte is accepted, hold stays full, no output.
    motor = 1'b0;
    src_q.push_back(8'h96);
    src_q.push_back(8'h69);
    run(20);
    motor = 1'b1;
    run(300);

    // Randomised traffic with random motor stops and valid gaps.
    for (int i = 0; i < 4000; i++) begin
      if (src_q.size() == 0 && $urandom_range(0, 99) < 4) begin
        int nb = $urandom_range(1, 3);
        for (int j = 0; j < nb; j++) src_q.push_back(8'($urandom));
      end
      if ($urandom_range(0, 99) < 2) motor = ~motor;
      src_en = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // Drain whatever remains with the motor running.
    motor = 1'b1;
    src_en = 1'b1;
    run(700);
    check("drain_idle_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
